fi_inject_ctrl: RTL and testbench
=================================

Name: fi_inject_ctrl

Overview:
Synthesizable fault-injection scheduler for NVDLA RTL fault-injection campaigns. It keeps a free-running core-cycle counter and sequences one or more timed injection windows on a target signal. During each window it corrupts the signal with a programmed mask, using bit-flip, stuck-at-0 or stuck-at-1. It sits between the golden signal and its consumer inside the injection harness, replacing hand-written force statements with a programmable, cycle-exact controller.

Parameters:
DATA_W, 32, width of target signal and mask
CNT_W, 32, width of cycle counter and start-cycle field
DUR_W, 16, width of duration and gap fields

Ports:
dla_core_clk  in  1  core clock
dla_core_rst  in  1  synchronous active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accept possible
cfg_start_cycle  in  CNT_W  counter value of first injected cycle
cfg_duration  in  DUR_W  cycles per window (0 treated as 1)
cfg_gap  in  DUR_W  idle cycles between windows
cfg_repeat  in  8  number of windows (0 treated as 1)
cfg_mode  in  2  00 flip, 01 SA0, 10 SA1, 11 dry-run
cfg_mask  in  DATA_W  bits to corrupt
abort  in  1  cancel campaign
sig_in  in  DATA_W  golden target value
sig_out  out  DATA_W  possibly corrupted value
counter  out  CNT_W  cycle counter
inj_active  out  1  injection window active
win_cnt  out  8  completed windows
done  out  1  campaign complete
late  out  1  start cycle already passed at accept

Behaviour:
- Reset (synchronous, priority over everything): counter=0, state=IDLE, inj_active=0, win_cnt=0, done=0, late=0, all cfg registers=0.
- counter increments every non-reset cycle and wraps 2^CNT_W-1 -> 0. It never stops for any state.
- States: IDLE, WAIT, INJECT, GAP, DONE.
- cfg_ready=1 only in IDLE and DONE. Accept = cfg_valid & cfg_ready. On accept: latch all cfg fields (duration and repeat clamped to at least 1), clear done, late and win_cnt.
- Accept timing, where C is the counter value in the accept cycle:
  - start >= C+2: go to WAIT, late=0.
  - start == C+1: go to INJECT, late=0.
  - start <= C: go to INJECT, late=1 (unsigned compare; no wrap handling).
- WAIT -> INJECT is timed so that the first inj_active cycle shows counter == start_cycle.
- INJECT: inj_active=1 for exactly duration cycles. At the last cycle, win_cnt increments.
  - If win_cnt+1 == repeat: go to DONE.
  - Else if gap == 0: re-enter INJECT (inj_active continuous).
  - Else: go to GAP.
- GAP: inj_active=0 for exactly gap cycles, then INJECT.
- DONE: done=1 (level) until next accept or reset. inj_active=0.
- inj_active is a registered, state-decoded output.
- sig_out is combinational:
  - inj_active=0: sig_in.
  - flip: sig_in ^ mask.
  - SA0: sig_in & ~mask.
  - SA1: sig_in | mask.
  - dry-run: sig_in (timing, win_cnt and done still run).
  - Zero latency from sig_in to sig_out.
- abort: from any non-reset state, go to IDLE on the next edge. inj_active=0 from the next cycle. done stays 0; win_cnt holds its value. abort outranks a simultaneous accept (no accept occurs) and all window transitions.
- Reset mid-window: sig_out=sig_in in the cycle following the reset edge.
- DUR_W counters are internal down-counters; no arithmetic overflow is permitted for duration or gap = 2^DUR_W-1.

Test Plan:
1. Reset, accept at counter=5 with start=100, dur=3, repeat=1, flip, mask=0x0000_0001, sig_in=0xA -> inj_active high at counter 100..102, sig_out=0xB in those cycles, else 0xA; done=1 from counter 103; win_cnt=1.
2. Start=200, dur=2, gap=3, repeat=3, SA1, mask=0xF0, sig_in=0x0F -> active at 200-201, 205-206, 210-211; sig_out=0xFF while active; win_cnt steps 1,2,3; done at 212.
3. gap=0, dur=4, repeat=2, SA0, mask=0xFF, sig_in=0x1FF -> active 8 consecutive cycles, sig_out=0x100; win_cnt increments twice.
4. Accept at counter=50 with start=10 -> late=1; inj_active first seen at counter 51 for duration cycles. Separately, start=51 at counter=50 -> late=0; first active cycle at counter 51.
5. Assert abort in the second cycle of a 10-cycle window -> inj_active=0 next cycle; state IDLE; cfg_ready=1; done=0; win_cnt=0. A cfg_valid asserted with abort in the same cycle is not accepted.
6. Assert dla_core_rst during GAP -> all outputs reach reset values at the next edge and counter restarts at 0. Dry-run mode then gives sig_out == sig_in throughout while win_cnt and done still sequence.

Source files
------------

// File: rtl/fi_inject_ctrl.sv
// Cycle-exact fault-injection scheduler: runs timed injection windows against a free-running
// core-cycle counter and corrupts the target signal with a mask (flip / SA0 / SA1 / dry-run).
module fi_inject_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32,
   parameter int DUR_W  = 16
) (
   input  logic              dla_core_clk,
   input  logic              dla_core_rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_start_cycle,
   input  logic [DUR_W-1:0]  cfg_duration,
   input  logic [DUR_W-1:0]  cfg_gap,
   input  logic [7:0]        cfg_repeat,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_mask,
   input  logic              abort,
   input  logic [DATA_W-1:0] sig_in,
   output logic [DATA_W-1:0] sig_out,
   output logic [CNT_W-1:0]  counter,
   output logic              inj_active,
   output logic [7:0]        win_cnt,
   output logic              done,
   output logic              late
);

   typedef enum logic [2:0] {IDLE, WAIT, INJECT, GAP, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [DUR_W-1:0] DUR_ONE = 1;
   localparam logic [CNT_W:0]   EXT_ONE = 1;
   localparam logic [CNT_W:0]   EXT_TWO = 2;

   state_t            state_reg;
   logic [CNT_W-1:0]  counter_reg;
   logic [CNT_W-1:0]  start_reg;
   logic [DUR_W-1:0]  dur_reg;
   logic [DUR_W-1:0]  gap_reg;
   logic [DUR_W-1:0]  rem_reg;
   logic [7:0]        rep_reg;
   logic [7:0]        win_reg;
   logic [1:0]        mode_reg;
   logic [DATA_W-1:0] mask_reg;
   logic              act_reg;
   logic              done_reg;
   logic              late_reg;

   logic [DUR_W-1:0]  dur_clamped;
   logic [7:0]        rep_clamped;
   logic [CNT_W:0]    cnt_ext;
   logic [CNT_W:0]    start_ext;
   logic              last_win;

   assign dur_clamped = (cfg_duration == '0) ? DUR_ONE : cfg_duration;
   assign rep_clamped = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
   // Extra bit keeps the start-cycle comparisons free of counter wrap.
   assign cnt_ext     = {1'b0, counter_reg};
   assign start_ext   = {1'b0, cfg_start_cycle};
   assign last_win    = (win_reg + 8'd1) == rep_reg;

   assign cfg_ready  = (state_reg == IDLE) || (state_reg == DONE);
   assign counter    = counter_reg;
   assign inj_active = act_reg;
   assign win_cnt    = win_reg;
   assign done       = done_reg;
   assign late       = late_reg;

   always_ff @(posedge dla_core_clk) begin
      if (dla_core_rst) begin
         state_reg   <= IDLE;
         counter_reg <= '0;
         start_reg   <= '0;
         dur_reg     <= '0;
         gap_reg     <= '0;
         rem_reg     <= '0;
         rep_reg     <= '0;
         win_reg     <= '0;
         mode_reg    <= '0;
         mask_reg    <= '0;
         act_reg     <= 1'b0;
         done_reg    <= 1'b0;
         late_reg    <= 1'b0;
      end else begin
         counter_reg <= counter_reg + CNT_ONE;
         if (abort) begin
            state_reg <= IDLE;
            act_reg   <= 1'b0;
            done_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE, DONE: begin
                  if (cfg_valid) begin
                     start_reg <= cfg_start_cycle;
                     dur_reg   <= dur_clamped;
                     gap_reg   <= cfg_gap;
                     rep_reg   <= rep_clamped;
                     mode_reg  <= cfg_mode;
                     mask_reg  <= cfg_mask;
                     win_reg   <= '0;
                     done_reg  <= 1'b0;
                     if (start_ext >= cnt_ext + EXT_TWO) begin
                        state_reg <= WAIT;
                        act_reg   <= 1'b0;
                        late_reg  <= 1'b0;
                     end else begin
                        state_reg <= INJECT;
                        act_reg   <= 1'b1;
                        rem_reg   <= dur_clamped - DUR_ONE;
                        late_reg  <= (start_ext != cnt_ext + EXT_ONE);
                     end
                  end
               end
               // Leave one cycle early so the first active cycle shows counter == start.
               WAIT: begin
                  if (counter_reg + CNT_ONE == start_reg) begin
                     state_reg <= INJECT;
                     act_reg   <= 1'b1;
                     rem_reg   <= dur_reg - DUR_ONE;
                  end
               end
               INJECT: begin
                  if (rem_reg == '0) begin
                     win_reg <= win_reg + 8'd1;
                     if (last_win) begin
                        state_reg <= DONE;
                        act_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                     end else if (gap_reg == '0) begin
                        rem_reg <= dur_reg - DUR_ONE;
                     end else begin
                        state_reg <= GAP;
                        act_reg   <= 1'b0;
                        rem_reg   <= gap_reg - DUR_ONE;
                     end
                  end else begin
                     rem_reg <= rem_reg - DUR_ONE;
                  end
               end
               GAP: begin
                  if (rem_reg == '0) begin
                     state_reg <= INJECT;
                     act_reg   <= 1'b1;
                     rem_reg   <= dur_reg - DUR_ONE;
                  end else begin
                     rem_reg <= rem_reg - DUR_ONE;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  act_reg   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Zero-latency corruption path; dry-run (11) passes the golden value through.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
         logic bad_bit;
         assign bad_bit = (mode_reg == 2'b00) ? ~sig_in[gi] :
                          (mode_reg == 2'b01) ? 1'b0 :
                          (mode_reg == 2'b10) ? 1'b1 : sig_in[gi];
         assign sig_out[gi] = (act_reg && mask_reg[gi]) ? bad_bit : sig_in[gi];
      end
   endgenerate

endmodule

// File: tb/tb_fi_inject_ctrl.sv
// Directed bench for fi_inject_ctrl: hand-computed windows, corruption values, abort and reset cases.
module tb_fi_inject_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_start_cycle;
   logic [15:0] cfg_duration;
   logic [15:0] cfg_gap;
   logic [7:0]  cfg_repeat;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_mask;
   logic        abort;
   logic [31:0] sig_in;
   logic [31:0] sig_out;
   logic [31:0] counter;
   logic        inj_active;
   logic [7:0]  win_cnt;
   logic        done;
   logic        late;

   int n_vec = 0;
   int n_err = 0;

   fi_inject_ctrl dut (
      .dla_core_clk    (clk),
      .dla_core_rst    (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_start_cycle (cfg_start_cycle),
      .cfg_duration    (cfg_duration),
      .cfg_gap         (cfg_gap),
      .cfg_repeat      (cfg_repeat),
      .cfg_mode        (cfg_mode),
      .cfg_mask        (cfg_mask),
      .abort           (abort),
      .sig_in          (sig_in),
      .sig_out         (sig_out),
      .counter         (counter),
      .inj_active      (inj_active),
      .win_cnt         (win_cnt),
      .done            (done),
      .late            (late)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (counter=%0d)", tag, obs, exp, counter);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input logic [31:0] start, input logic [15:0] dur, input logic [15:0] gap,
                            input logic [7:0] rep, input logic [1:0] mode, input logic [31:0] mask);
      cfg_start_cycle = start;
      cfg_duration    = dur;
      cfg_gap         = gap;
      cfg_repeat      = rep;
      cfg_mode        = mode;
      cfg_mask        = mask;
      cfg_valid       = 1'b1;
      $display("accept at counter=%0d start=%0d dur=%0d gap=%0d rep=%0d mode=%0d mask=%h",
               counter, start, dur, gap, rep, mode, mask);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_cnt(input logic [31:0] v);
      int guard = 0;
      while (counter != v && guard < 5000) begin
         tick();
         guard++;
      end
      chk("wait_cnt", counter, v);
   endtask

   // Walk cycles up to (not including) counter == upto, checking activity against up to three ranges.
   task automatic scan(input logic [31:0] upto,
                       input logic [31:0] l0, input logic [31:0] h0,
                       input logic [31:0] l1, input logic [31:0] h1,
                       input logic [31:0] l2, input logic [31:0] h2,
                       input logic [31:0] von, input logic [31:0] voff, input string tag);
      int   guard = 0;
      logic e;
      while (counter != upto && guard < 5000) begin
         e = (counter >= l0 && counter <= h0) || (counter >= l1 && counter <= h1) ||
             (counter >= l2 && counter <= h2);
         chk({tag, "_act"}, inj_active, e);
         chk({tag, "_sig"}, sig_out, e ? von : voff);
         tick();
         guard++;
      end
      chk({tag, "_end"}, counter, upto);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0; sig_in = 32'h0;
      cfg_start_cycle = 0; cfg_duration = 0; cfg_gap = 0; cfg_repeat = 0; cfg_mode = 0; cfg_mask = 0;
      tick();
      tick();
      chk("rst_counter", counter, 0);
      chk("rst_active", inj_active, 0);
      chk("rst_win", win_cnt, 0);
      chk("rst_done", done, 0);
      chk("rst_late", late, 0);
      chk("rst_ready", cfg_ready, 1);
      rst = 1'b0;

      // 1: single flip window at 100..102
      sig_in = 32'hA;
      wait_cnt(5);
      do_accept(100, 3, 0, 1, 2'b00, 32'h1);
      chk("t1_ready", cfg_ready, 0);
      chk("t1_late", late, 0);
      scan(102, 100, 101, 1, 0, 1, 0, 32'hB, 32'hA, "t1");
      chk("t1_act102", inj_active, 1);
      chk("t1_sig102", sig_out, 32'hB);
      chk("t1_done102", done, 0);
      tick();
      chk("t1_act103", inj_active, 0);
      chk("t1_sig103", sig_out, 32'hA);
      chk("t1_done103", done, 1);
      chk("t1_win", win_cnt, 1);
      chk("t1_ready_done", cfg_ready, 1);

      // 2: three SA1 windows with gap 3
      sig_in = 32'h0F;
      do_accept(200, 2, 3, 3, 2'b10, 32'hF0);
      scan(202, 200, 201, 205, 206, 210, 211, 32'hFF, 32'h0F, "t2a");
      chk("t2_win1", win_cnt, 1);
      scan(207, 200, 201, 205, 206, 210, 211, 32'hFF, 32'h0F, "t2b");
      chk("t2_win2", win_cnt, 2);
      chk("t2_done_mid", done, 0);
      scan(212, 200, 201, 205, 206, 210, 211, 32'hFF, 32'h0F, "t2c");
      chk("t2_win3", win_cnt, 3);
      chk("t2_done", done, 1);

      // 3: back-to-back SA0 windows, gap 0
      sig_in = 32'h1FF;
      do_accept(220, 4, 0, 2, 2'b01, 32'hFF);
      scan(224, 220, 227, 1, 0, 1, 0, 32'h100, 32'h1FF, "t3a");
      chk("t3_win1", win_cnt, 1);
      scan(228, 220, 227, 1, 0, 1, 0, 32'h100, 32'h1FF, "t3b");
      chk("t3_win2", win_cnt, 2);
      chk("t3_done", done, 1);

      // 4: late start, exact start, and WAIT boundary
      do_reset();
      sig_in = 32'h0;
      wait_cnt(50);
      do_accept(10, 2, 0, 1, 2'b00, 32'h3);
      chk("t4_late", late, 1);
      chk("t4_act51", inj_active, 1);
      chk("t4_sig51", sig_out, 32'h3);
      tick();
      chk("t4_act52", inj_active, 1);
      tick();
      chk("t4_act53", inj_active, 0);
      chk("t4_done53", done, 1);
      do_reset();
      wait_cnt(50);
      do_accept(51, 1, 0, 1, 2'b00, 32'h3);
      chk("t4b_late", late, 0);
      chk("t4b_act51", inj_active, 1);
      tick();
      chk("t4b_act52", inj_active, 0);
      chk("t4b_done52", done, 1);
      do_accept(54, 1, 0, 1, 2'b00, 32'h3);
      chk("t4c_act53", inj_active, 0);
      chk("t4c_ready53", cfg_ready, 0);
      chk("t4c_done53", done, 0);
      tick();
      chk("t4c_act54", inj_active, 1);
      chk("t4c_cnt54", counter, 54);
      tick();
      chk("t4c_done55", done, 1);

      // 5: abort in second cycle of a 10-cycle window
      sig_in = 32'h0F;
      do_accept(56, 10, 0, 1, 2'b00, 32'hF0);
      chk("t5_act56", inj_active, 1);
      chk("t5_sig56", sig_out, 32'hFF);
      tick();
      abort = 1'b1;
      cfg_valid = 1'b1;
      tick();
      chk("t5_act", inj_active, 0);
      chk("t5_sig", sig_out, 32'h0F);
      chk("t5_ready", cfg_ready, 1);
      chk("t5_done", done, 0);
      chk("t5_win", win_cnt, 0);
      cfg_start_cycle = 59;
      cfg_duration = 2;
      tick();
      abort = 1'b0;
      cfg_valid = 1'b0;
      chk("t5_noacc_act", inj_active, 0);
      chk("t5_noacc_ready", cfg_ready, 1);
      tick();
      chk("t5_noacc_act2", inj_active, 0);

      // 6: reset during GAP, then dry-run sequencing
      sig_in = 32'h55;
      do_accept(61, 2, 5, 3, 2'b00, 32'hFF);
      chk("t6_act61", inj_active, 1);
      chk("t6_sig61", sig_out, 32'hAA);
      tick();
      tick();
      chk("t6_gap_act", inj_active, 0);
      chk("t6_gap_win", win_cnt, 1);
      rst = 1'b1;
      tick();
      chk("t6_rst_cnt", counter, 0);
      chk("t6_rst_act", inj_active, 0);
      chk("t6_rst_win", win_cnt, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_late", late, 0);
      chk("t6_rst_ready", cfg_ready, 1);
      chk("t6_rst_sig", sig_out, 32'h55);
      rst = 1'b0;
      tick();
      chk("t6_cnt1", counter, 1);
      do_accept(5, 2, 1, 2, 2'b11, 32'hFF);
      scan(7, 5, 6, 8, 9, 1, 0, 32'h55, 32'h55, "t6a");
      chk("t6_dry_win1", win_cnt, 1);
      chk("t6_dry_done_mid", done, 0);
      scan(10, 5, 6, 8, 9, 1, 0, 32'h55, 32'h55, "t6b");
      chk("t6_dry_win2", win_cnt, 2);
      chk("t6_dry_done", done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
